// File: rtl/jt7759_pkg.sv
// Shared constants for the JT7759 ROM responder: address widths, byte order
// and the one-hot FSM encoding.
package jt7759_pkg;

    localparam int BADDR_W = 17;
    localparam int WADDR_W = 16;
    localparam int WORD_W  = 16;
    localparam int BYTE_W  = 8;

    // Odd byte addresses read the upper half of a memory word.
    localparam bit ODD_BYTE_HI = 1'b1;

    localparam logic [2:0] ST_IDLE  = 3'b001;
    localparam logic [2:0] ST_FETCH = 3'b010;
    localparam logic [2:0] ST_PREF  = 3'b100;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        PREF  = ST_PREF
    } state_e;

    function automatic logic [BYTE_W-1:0] sel_byte(input logic [WORD_W-1:0] w,
                                                   input logic              odd);
        return (odd == ODD_BYTE_HI) ? w[15:8] : w[7:0];
    endfunction

endpackage

// File: rtl/jt7759_romif_entry.sv
// One word-buffer entry: valid/tag/data with a write port, flush, and tag
// compares against the current and the following word address.
module jt7759_romif_entry
    import jt7759_pkg::*;
(
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               flush_i,
    input  logic               we_i,
    input  logic [WADDR_W-1:0] wtag_i,
    input  logic [WORD_W-1:0]  wdata_i,
    input  logic [WADDR_W-1:0] cur_tag_i,
    input  logic [WADDR_W-1:0] nxt_tag_i,
    output logic [WORD_W-1:0]  data_o,
    output logic               hit_cur_o,
    output logic               hit_nxt_o
);

    logic               valid_q;
    logic [WADDR_W-1:0] tag_q;
    logic [WORD_W-1:0]  data_q;

    // Flush wins over a write landing in the same cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (we_i) begin
            valid_q <= 1'b1;
            tag_q   <= wtag_i;
            data_q  <= wdata_i;
        end
    end

    assign data_o    = data_q;
    assign hit_cur_o = valid_q && (tag_q == cur_tag_i);
    assign hit_nxt_o = valid_q && (tag_q == nxt_tag_i);

endmodule

// File: rtl/jt7759_romif.sv
// ROM responder for the JT7759 controller: serves byte reads from a two-entry
// word buffer, fetching misses and prefetching the next word over req/ack.
module jt7759_romif
    import jt7759_pkg::*;
(
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               flush_i,
    input  logic               rom_cs_i,
    input  logic [BADDR_W-1:0] rom_addr_i,
    output logic [BYTE_W-1:0]  rom_data_o,
    output logic               rom_ok_o,
    output logic               mem_req_o,
    output logic [WADDR_W-1:0] mem_addr_o,
    input  logic [WORD_W-1:0]  mem_data_i,
    input  logic               mem_ack_i
);

    state_e state_q, state_d;
    logic                req_q, req_d;
    logic [WADDR_W-1:0]  maddr_q, maddr_d;
    logic                pway_q, pway_d;
    logic                lru_q, lru_d;
    logic                drop_q, drop_d;
    logic                ok_q;
    logic [BADDR_W-1:0]  addr_q;
    logic [BYTE_W-1:0]   data_q;

    logic [WADDR_W-1:0]        cur_w, nxt_w;
    logic [1:0]                hit_cur, hit_nxt, we;
    logic [1:0][WORD_W-1:0]    edata;
    logic                      hit, hit_way, nxt_buf, fill, fill_way;
    logic [WORD_W-1:0]         hit_word;

    assign cur_w = rom_addr_i[BADDR_W-1:1];
    assign nxt_w = cur_w + 16'd1;

    for (genvar g = 0; g < 2; g++) begin : g_entry
        jt7759_romif_entry u_entry (
            .clk_i     (clk_i),
            .rstn_i    (rstn_i),
            .flush_i   (flush_i),
            .we_i      (we[g]),
            .wtag_i    (maddr_q),
            .wdata_i   (mem_data_i),
            .cur_tag_i (cur_w),
            .nxt_tag_i (nxt_w),
            .data_o    (edata[g]),
            .hit_cur_o (hit_cur[g]),
            .hit_nxt_o (hit_nxt[g])
        );
    end

    assign hit      = rom_cs_i && (|hit_cur);
    assign hit_way  = hit_cur[1];
    assign hit_word = edata[hit_way];
    assign nxt_buf  = |hit_nxt;

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        maddr_d  = maddr_q;
        pway_d   = pway_q;
        fill     = 1'b0;
        fill_way = lru_q;
        case (state_q)
            IDLE: begin
                if (rom_cs_i && !hit) begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                    maddr_d = cur_w;
                end else if (hit && !nxt_buf) begin
                    // Prefetch lands in the entry not serving the current word.
                    state_d = PREF;
                    req_d   = 1'b1;
                    maddr_d = nxt_w;
                    pway_d  = ~hit_way;
                end
            end
            FETCH: begin
                if (mem_ack_i) begin
                    fill     = 1'b1;
                    fill_way = lru_q;
                    req_d    = 1'b0;
                    state_d  = IDLE;
                end
            end
            PREF: begin
                if (mem_ack_i) begin
                    fill     = 1'b1;
                    fill_way = pway_q;
                    req_d    = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // A flush while a request is (or becomes) outstanding poisons its fill.
    always_comb begin
        drop_d = drop_q;
        if (fill)
            drop_d = 1'b0;
        if (flush_i && (state_d != IDLE))
            drop_d = 1'b1;
    end

    always_comb begin
        we = '0;
        if (fill && !drop_q)
            we[fill_way] = 1'b1;
    end

    always_comb begin
        lru_d = lru_q;
        if (hit)
            lru_d = ~hit_way;
        if (fill)
            lru_d = ~fill_way;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            maddr_q <= '0;
            pway_q  <= 1'b0;
            lru_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            maddr_q <= maddr_d;
            pway_q  <= pway_d;
            lru_q   <= lru_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ok_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            ok_q <= hit && !flush_i;
            if (hit) begin
                addr_q <= rom_addr_i;
                data_q <= sel_byte(hit_word, rom_addr_i[0]);
            end
        end
    end

    // Gating against the live address keeps a stale ok from leaking out.
    assign rom_ok_o   = ok_q && rom_cs_i && (addr_q == rom_addr_i);
    assign rom_data_o = data_q;
    assign mem_req_o  = req_q;
    assign mem_addr_o = maddr_q;

endmodule

// File: tb/tb_jt7759_romif.sv
// Bench for jt7759_romif: directed corner sequences, a vector table and a
// randomized read stream checked against a ROM content model.
module tb_jt7759_romif;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        rom_cs = 1'b0;
    logic [16:0] rom_addr = '0;
    logic [7:0]  rom_data;
    logic        rom_ok;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_data = '0;
    logic        mem_ack = 1'b0;

    int errors = 0;
    int checks = 0;
    bit mem_auto = 1'b0;
    bit rand_lat = 1'b0;
    bit mon_en = 1'b0;
    int lat = 3;
    logic [15:0] last_req = '0;

    always #5 clk = ~clk;

    jt7759_romif dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .flush_i    (flush),
        .rom_cs_i   (rom_cs),
        .rom_addr_i (rom_addr),
        .rom_data_o (rom_data),
        .rom_ok_o   (rom_ok),
        .mem_req_o  (mem_req),
        .mem_addr_o (mem_addr),
        .mem_data_i (mem_data),
        .mem_ack_i  (mem_ack)
    );

    // ROM contents as seen by the memory side.
    function automatic logic [15:0] rom_word(input logic [15:0] w);
        if (w == 16'h0002) return 16'hA55A;
        return {w[7:0] ^ 8'h3C, w[15:8] + w[7:0] + 8'h11};
    endfunction

    function automatic logic [7:0] exp_byte(input logic [16:0] a);
        logic [15:0] w;
        w = rom_word(a[16:1]);
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_le(input string name, input int got, input int lim);
        checks++;
        if (got > lim) begin
            errors++;
            $display("FAIL %s: got %0d expected at most %0d", name, got, lim);
        end
    endtask

    // Memory responder: acks after 'lat' cycles of seeing mem_req.
    initial begin : responder
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!mem_auto) cnt = 0;
            else if (mem_ack) mem_ack = 1'b0;
            else if (mem_req) begin
                cnt++;
                if (cnt >= lat) begin
                    mem_ack  = 1'b1;
                    mem_data = rom_word(mem_addr);
                    cnt = 0;
                    if (rand_lat) lat = $urandom_range(1, 6);
                end
            end else cnt = 0;
        end
    end

    // Handshake protocol monitor.
    initial begin : monitor
        logic rp, ap;
        logic [15:0] ad;
        rp = 1'b0; ap = 1'b0; ad = '0;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en && rp && !ap) begin
                check("req held until ack", mem_req, 1'b1);
                if (mem_req) check("mem_addr stable", mem_addr, ad);
            end
            if (mem_req && !rp) last_req = mem_addr;
            rp = mem_req; ap = mem_ack; ad = mem_addr;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_ok(input int bound, output int n);
        n = 0;
        while (n < bound) begin
            @(negedge clk);
            n++;
            if (rom_ok === 1'b1) return;
        end
        check("rom_ok timeout", 32'd0, 32'd1);
    endtask

    task automatic present(input logic [16:0] a, input bit pulse, input bit chk_drop);
        if (pulse) begin
            rom_cs = 1'b0;
            #1 check("rom_ok with cs low", rom_ok, 1'b0);
            @(negedge clk);
        end
        rom_addr = a;
        rom_cs   = 1'b1;
        if (chk_drop) begin
            #1 check("rom_ok on address change", rom_ok, 1'b0);
        end
    endtask

    task automatic hold(input int cyc, input logic [7:0] exp);
        for (int k = 0; k < cyc; k++) begin
            @(negedge clk);
            check("hold rom_ok", rom_ok, 1'b1);
            check("hold rom_data", rom_data, exp);
        end
    endtask

    typedef struct {
        logic [16:0] addr;
        bit          pulse;
        int          max_lat;
        bit          chk_drop;
        bit          chk_pref;
        logic [15:0] pref;
        logic [7:0]  exp;
    } vec_t;

    initial begin : main
        vec_t tbl[$];
        int n;
        logic [16:0] a, na;
        bit seq, fl, pl;

        for (int i = 4; i <= 11; i++)
            tbl.push_back('{17'(i), (i == 4) || (i[1] == 1'b1), (i == 4) ? 12 : 1, 1'b0, 1'b0, 16'h0, exp_byte(17'(i))});
        tbl.push_back('{17'h00004, 1'b1, 12, 1'b0, 1'b0, 16'h0, exp_byte(17'h00004)});
        tbl.push_back('{17'h10000, 1'b0, 12, 1'b1, 1'b0, 16'h0, exp_byte(17'h10000)});
        tbl.push_back('{17'h1FFFE, 1'b1, 12, 1'b0, 1'b1, 16'h0000, exp_byte(17'h1FFFE)});

        // Reset state
        repeat (3) @(negedge clk);
        check("reset rom_data", rom_data, 8'h00);
        check("reset rom_ok", rom_ok, 1'b0);
        check("reset mem_req", mem_req, 1'b0);
        check("reset mem_addr", mem_addr, 16'h0000);
        rstn = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // Cold read of 0x00005, ack 4 cycles after the request
        rom_addr = 17'h00005;
        rom_cs   = 1'b1;
        @(negedge clk);
        check("cold mem_req", mem_req, 1'b1);
        check("cold mem_addr", mem_addr, 16'h0002);
        check("cold rom_ok early", rom_ok, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("cold req waiting", mem_req, 1'b1);
        end
        mem_ack  = 1'b1;
        mem_data = 16'hA55A;
        @(negedge clk);
        mem_ack = 1'b0;
        check("ack+1 rom_ok", rom_ok, 1'b0);
        check("ack+1 mem_req", mem_req, 1'b0);
        @(negedge clk);
        check("ack+2 rom_ok", rom_ok, 1'b1);
        check("ack+2 rom_data", rom_data, 8'hA5);
        check("prefetch mem_req", mem_req, 1'b1);
        check("prefetch mem_addr", mem_addr, 16'h0003);

        // Hit on the other byte of the same word: one cycle
        present(17'h00004, 1'b0, 1'b1);
        @(negedge clk);
        check("hit latency rom_ok", rom_ok, 1'b1);
        check("hit rom_data", rom_data, 8'h5A);

        // Flush while the prefetch is in flight
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush rom_ok", rom_ok, 1'b0);
        check("flush req kept", mem_req, 1'b1);
        rom_cs   = 1'b0;
        mem_ack  = 1'b1;
        mem_data = rom_word(16'h0003);
        @(negedge clk);
        mem_ack = 1'b0;
        check("flushed pref done", mem_req, 1'b0);
        rom_cs   = 1'b1;
        rom_addr = 17'h00006;
        @(negedge clk);
        check("refetch mem_req", mem_req, 1'b1);
        check("refetch mem_addr", mem_addr, 16'h0003);
        check("refetch rom_ok", rom_ok, 1'b0);
        mem_ack  = 1'b1;
        mem_data = rom_word(16'h0003);
        @(negedge clk);
        mem_ack = 1'b0;
        wait_ok(4, n);
        check("refetch latency", n, 1);
        check("refetch rom_data", rom_data, exp_byte(17'h00006));
        check("pref after refetch req", mem_req, 1'b1);
        check("pref after refetch addr", mem_addr, 16'h0004);

        // Reset in the middle of a request, then a stray ack
        mon_en = 1'b0;
        rstn = 1'b0;
        #1;
        check("async reset mem_req", mem_req, 1'b0);
        check("async reset rom_ok", rom_ok, 1'b0);
        @(negedge clk);
        rstn   = 1'b1;
        rom_cs = 1'b0;
        @(negedge clk);
        mem_ack  = 1'b1;
        mem_data = rom_word(16'h0004);
        @(negedge clk);
        mem_ack = 1'b0;
        check("stray ack mem_req", mem_req, 1'b0);
        rom_cs   = 1'b1;
        rom_addr = 17'h00006;
        #1 check("post reset rom_ok", rom_ok, 1'b0);
        @(negedge clk);
        check("post reset miss req", mem_req, 1'b1);
        check("post reset miss addr", mem_addr, 16'h0003);
        check("post reset rom_ok", rom_ok, 1'b0);
        mon_en   = 1'b1;
        lat      = 3;
        mem_auto = 1'b1;
        wait_ok(20, n);
        check("post reset rom_data", rom_data, exp_byte(17'h00006));

        // Vector table, fixed 3-cycle memory latency
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        foreach (tbl[i]) begin
            present(tbl[i].addr, tbl[i].pulse, tbl[i].chk_drop);
            wait_ok(40, n);
            check_le($sformatf("latency %05h", tbl[i].addr), n, tbl[i].max_lat);
            check($sformatf("data %05h", tbl[i].addr), rom_data, tbl[i].exp);
            hold(8, tbl[i].exp);
            if (tbl[i].chk_pref) check("wrap prefetch addr", last_req, tbl[i].pref);
        end

        // Randomized stream: mostly sequential, some jumps and flushes
        rand_lat = 1'b1;
        a = 17'h1FFFE;
        for (int it = 0; it < 80; it++) begin
            seq = ($urandom_range(0, 9) < 7);
            fl  = ($urandom_range(0, 19) == 0);
            pl  = 1'($urandom_range(0, 1));
            na  = seq ? a + 17'd1 : 17'($urandom);
            if (fl) begin
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                check("rand flush rom_ok", rom_ok, 1'b0);
            end
            present(na, pl, na != a);
            wait_ok(60, n);
            if (seq && !fl) check_le("rand sequential latency", n, 1);
            check($sformatf("rand data %05h", na), rom_data, exp_byte(na));
            hold(8, exp_byte(na));
            a = na;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
